// File: rtl/mul32_seq_if.sv
// Operand/product handshake bundle for the sequential 32x32 multiplier.
// master drives operands and accepts products; slave is the multiplier.
interface mul32_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/mul32_seq.sv
// Sequential unsigned 32x32->64 shift-add multiplier, one partial product per cycle.
// Operands are taken in IDLE, 32 RUN cycles follow, and the product is held in DONE until consumed.

module rcadd32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  logic carry;

  always_comb begin
    s     = '0;
    carry = cin;
    for (int i = 0; i < 32; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end
endmodule

// state | meaning
// IDLE  | in_ready=1, waiting for an operand pair
// RUN   | one shift-add step per cycle, count 0..31, busy=1
// DONE  | out_valid=1, product held until out_ready
module mul32_seq (
  input  logic         clk,
  input  logic         rst,
  mul32_seq_if.slave   bus,
  output logic         busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] mcand, mcand_nxt;
  logic [31:0] hi, hi_nxt;
  logic [31:0] lo, lo_nxt;
  logic [4:0]  count, count_nxt;

  logic [31:0] addend;
  logic [31:0] add_s;
  logic        add_c;

  assign addend = lo[0] ? mcand : 32'd0;

  rcadd32 u_add (
    .a    (hi),
    .b    (addend),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      mcand <= mcand_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    mcand_nxt     = mcand;
    hi_nxt        = hi;
    lo_nxt        = lo;
    count_nxt     = count;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          mcand_nxt = bus.a;
          lo_nxt    = bus.b;
          hi_nxt    = '0;
          count_nxt = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // The adder carry becomes the new MSB so the full 64-bit product survives the shift.
        {hi_nxt, lo_nxt} = {add_c, add_s, lo[31:1]};
        count_nxt = count + 5'd1;
        if (count == 5'd31) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.product = {hi, lo};
endmodule

// File: doc/mul32_seq.md
MUL32_SEQ -- requirements
Module: mul32_seq

Interface
REQ-001 No parameters; operand width SHALL be fixed at 32 bits and product width at 64 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair a/b valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  32  multiplicand, unsigned.
REQ-007 b  input  32  multiplier, unsigned.
REQ-008 out_valid  output  1  product valid.
REQ-009 out_ready  input  1  consumer accepts product.
REQ-010 product  output  64  unsigned a*b.
REQ-011 busy  output  1  high in RUN state.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE: in_ready=1. in_valid=1 at an edge SHALL capture a into the multiplicand register, load lo=b, hi=0 and count=0, and move to RUN.
REQ-014 in_ready SHALL be 0 in RUN and DONE; in_valid, a and b SHALL be ignored there.
REQ-015 Each RUN cycle SHALL form {c,s} = hi + (lo[0] ? mcand : 0) using the team's 32-bit ripple-carry adder rcadd32 with cin=0, then load {hi,lo} = {c,s,lo[31:1]} and increment count.
REQ-016 RUN SHALL last exactly 32 cycles; at the edge that processes count=31, state SHALL go to DONE.
REQ-017 Latency: if operands are accepted at edge E0, out_valid SHALL be high immediately after edge E32 with product={hi,lo}.
REQ-018 DONE: out_valid=1; product SHALL hold stable while out_ready=0 (backpressure, unbounded).
REQ-019 out_valid=1 and out_ready=1 at an edge SHALL return the FSM to IDLE; out_valid SHALL fall and in_ready SHALL rise after that edge. No same-edge accept of new operands.
REQ-020 busy SHALL be 1 exactly when state=RUN.
REQ-021 product SHALL be driven from registers only, with no combinational path from a, b or in_valid.
REQ-022 The carry out of each step SHALL be retained through the shift, so products up to 0xFFFFFFFE00000001 are exact, with no truncation.
REQ-023 out_ready SHALL be ignored outside DONE.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, count=0, hi=0, lo=0, mcand=0, regardless of state, including mid-RUN and in DONE. Any in-flight result SHALL be discarded.
REQ-025 Post-reset outputs SHALL be: in_ready=1, out_valid=0, busy=0, product=0.
REQ-026 rst SHALL take priority over in_valid and out_ready on the same edge.

Verification
REQ-027 a=3, b=5, in_valid pulse, out_ready=1 -> out_valid after exactly 32 edges past accept, product=0x000000000000000F; then one cycle out_valid, then in_ready=1.
REQ-028 a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001.
REQ-029 a=0x12345678, b=0 and a=0, b=0xDEADBEEF -> product=0 in both cases; latency still 32.
REQ-030 a=0x80000000, b=0x80000000 with out_ready held 0 for 10 cycles after out_valid -> product=0x4000000000000000 stable all 10 cycles; accepted on the first out_ready=1 edge.
REQ-031 Accept a=7, b=9; assert in_valid with a=1, b=1 during RUN; assert rst at RUN count=15 -> in_ready=1, busy=0, out_valid=0 next cycle. A fresh a=7, b=9 then yields 63 after 32 edges, and the in-RUN operands never appear.
REQ-032 Back-to-back: two transactions with in_valid held high and out_ready=1 -> accept edges 34 cycles apart (32 RUN + DONE + IDLE), with products correct and in order.
